// File: rtl/ldp_video_out.sv
// ldp_video_out: pass-through / test-pattern formatter for the decoder pixel stream.
// Latency PIPE dot_clk cycles, timing and colour aligned; no backpressure (free-running stream).
module ldp_video_out #(
  parameter int          DW        = 8,
  parameter int          PIPE      = 2,
  parameter int          BAR_SHIFT = 4,
  parameter logic [23:0] ERR_RGB   = 24'hFF0000,
  parameter logic [23:0] SYNC_RGB  = 24'hFF00FF,
  parameter logic [23:0] BLANK_RGB = 24'h444444
) (
  input  logic          dot_clk,
  input  logic          rst,
  input  logic [1:0]    mode_in,
  input  logic          mode_wr,
  input  logic [3*DW-1:0] fill_in,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_g,
  input  logic [DW-1:0] in_b,
  input  logic          in_valid,
  input  logic          in_pixel_en,
  input  logic          in_h_sync,
  input  logic          in_v_sync,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_g,
  output logic [DW-1:0] out_b,
  output logic          out_pixel_en,
  output logic          out_h_sync,
  output logic          out_v_sync,
  output logic [10:0]   x_pos,
  output logic [9:0]    y_pos,
  output logic [15:0]   underflow_cnt
);

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t pix;
    logic pixel_en;
    logic h_sync;
    logic v_sync;
  } stage_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_BARS = 2'd1,
    MODE_FILL = 2'd2,
    MODE_GRID = 2'd3
  } mode_t;

  // 8-bit colour constants are placed in the top bits of a DW-wide component.
  function automatic logic [DW-1:0] align8(input logic [7:0] c);
    return DW'({c, {DW{1'b0}}} >> 8);
  endfunction

  localparam rgb_t ERR_C   = {align8(ERR_RGB[23:16]),   align8(ERR_RGB[15:8]),   align8(ERR_RGB[7:0])};
  localparam rgb_t SYNC_C  = {align8(SYNC_RGB[23:16]),  align8(SYNC_RGB[15:8]),  align8(SYNC_RGB[7:0])};
  localparam rgb_t BLANK_C = {align8(BLANK_RGB[23:16]), align8(BLANK_RGB[15:8]), align8(BLANK_RGB[7:0])};
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic   h_prev, v_prev;
  logic   h_rise, v_rise;
  mode_t  shadow_mode, active_mode, shadow_mode_nxt, eff_mode;
  rgb_t   shadow_fill, active_fill, shadow_fill_nxt, eff_fill;
  rgb_t   mode_pix;
  logic [2:0] bar_k;
  logic   underflow;
  stage_t st0;
  stage_t pipe_q [PIPE];

  assign h_rise = in_h_sync & ~h_prev;
  assign v_rise = in_v_sync & ~v_prev;

  // A strobe coinciding with the frame start must take effect on that very pixel.
  assign shadow_mode_nxt = mode_wr ? mode_t'(mode_in) : shadow_mode;
  assign shadow_fill_nxt = mode_wr ? rgb_t'(fill_in)  : shadow_fill;
  assign eff_mode        = v_rise  ? shadow_mode_nxt  : active_mode;
  assign eff_fill        = v_rise  ? shadow_fill_nxt  : active_fill;

  assign bar_k = x_pos[BAR_SHIFT+2:BAR_SHIFT];

  always_comb begin
    mode_pix  = '0;
    underflow = 1'b0;
    case (eff_mode)
      MODE_PASS: begin
        if (in_valid) begin
          mode_pix.r = in_r;
          mode_pix.g = in_g;
          mode_pix.b = in_b;
        end else begin
          mode_pix  = ERR_C;
          underflow = in_pixel_en;
        end
      end
      MODE_BARS: begin
        mode_pix.r = bar_k[1] ? '0 : ONES;
        mode_pix.g = bar_k[2] ? '0 : ONES;
        mode_pix.b = bar_k[0] ? '0 : ONES;
      end
      MODE_FILL: mode_pix = eff_fill;
      MODE_GRID: begin
        if ((x_pos[3:0] == 4'd0) || (y_pos[3:0] == 4'd0))
          mode_pix = {ONES, ONES, ONES};
      end
      default: mode_pix = '0;
    endcase
  end

  always_comb begin
    st0          = '0;
    st0.pixel_en = in_pixel_en;
    st0.h_sync   = in_h_sync;
    st0.v_sync   = in_v_sync;
    if (in_pixel_en)
      st0.pix = mode_pix;
    else if (in_h_sync || in_v_sync)
      st0.pix = SYNC_C;
    else
      st0.pix = BLANK_C;
  end

  always_ff @(posedge dot_clk or posedge rst) begin
    if (rst) begin
      h_prev      <= 1'b0;
      v_prev      <= 1'b0;
      shadow_mode <= MODE_PASS;
      active_mode <= MODE_PASS;
      shadow_fill <= '0;
      active_fill <= '0;
    end else begin
      h_prev      <= in_h_sync;
      v_prev      <= in_v_sync;
      shadow_mode <= shadow_mode_nxt;
      shadow_fill <= shadow_fill_nxt;
      active_mode <= eff_mode;
      active_fill <= eff_fill;
    end
  end

  always_ff @(posedge dot_clk or posedge rst) begin
    if (rst) begin
      x_pos <= '0;
      y_pos <= '0;
    end else begin
      if (h_rise)
        x_pos <= '0;
      else if (in_pixel_en && (x_pos != 11'd2047))
        x_pos <= x_pos + 11'd1;

      if (v_rise)
        y_pos <= '0;
      else if (h_rise && (y_pos != 10'd1023))
        y_pos <= y_pos + 10'd1;
    end
  end

  always_ff @(posedge dot_clk or posedge rst) begin
    if (rst)
      underflow_cnt <= '0;
    else if (underflow && (underflow_cnt != 16'hFFFF))
      underflow_cnt <= underflow_cnt + 16'd1;
  end

  always_ff @(posedge dot_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++)
        pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= st0;
      for (int i = 1; i < PIPE; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_r        = pipe_q[PIPE-1].pix.r;
  assign out_g        = pipe_q[PIPE-1].pix.g;
  assign out_b        = pipe_q[PIPE-1].pix.b;
  assign out_pixel_en = pipe_q[PIPE-1].pixel_en;
  assign out_h_sync   = pipe_q[PIPE-1].h_sync;
  assign out_v_sync   = pipe_q[PIPE-1].v_sync;

endmodule

// File: tb/tb_ldp_video_out.sv
// Directed bench for ldp_video_out: per-cycle expectations queued at drive time, popped PIPE cycles later.
module tb_ldp_video_out;
  localparam int DW   = 8;
  localparam int PIPE = 2;

  logic          dot_clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode_in = 2'd0;
  logic          mode_wr = 1'b0;
  logic [3*DW-1:0] fill_in = '0;
  logic [DW-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic          in_valid = 1'b0, in_pixel_en = 1'b0, in_h_sync = 1'b0, in_v_sync = 1'b0;
  logic [DW-1:0] out_r, out_g, out_b;
  logic          out_pixel_en, out_h_sync, out_v_sync;
  logic [10:0]   x_pos;
  logic [9:0]    y_pos;
  logic [15:0]   underflow_cnt;

  ldp_video_out #(.DW(DW), .PIPE(PIPE)) dut (
    .dot_clk(dot_clk), .rst(rst), .mode_in(mode_in), .mode_wr(mode_wr), .fill_in(fill_in),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_valid(in_valid), .in_pixel_en(in_pixel_en),
    .in_h_sync(in_h_sync), .in_v_sync(in_v_sync), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_pixel_en(out_pixel_en), .out_h_sync(out_h_sync), .out_v_sync(out_v_sync),
    .x_pos(x_pos), .y_pos(y_pos), .underflow_cnt(underflow_cnt)
  );

  always #5 dot_clk = ~dot_clk;

  typedef struct {
    bit          en;
    logic [26:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  logic wr_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [31:0] out_word();
    return 32'({out_r, out_g, out_b, out_pixel_en, out_h_sync, out_v_sync});
  endfunction

  // One dot_clk cycle: check the output due now, then drive this cycle's input.
  task automatic step(input logic pe, input logic hs, input logic vs, input logic valid,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [23:0] e, input bit en, input string tag);
    exp_t x;
    @(negedge dot_clk);
    if (sb.size() >= PIPE) begin
      x = sb.pop_front();
      if (x.en) chk(x.tag, out_word(), 32'(x.val));
    end
    rst         = 1'b0;
    mode_wr     = wr_pend;
    wr_pend     = 1'b0;
    in_pixel_en = pe;
    in_h_sync   = hs;
    in_v_sync   = vs;
    in_valid    = valid;
    in_r        = r;
    in_g        = g;
    in_b        = b;
    x.en  = en;
    x.val = {e, pe, hs, vs};
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic after_edge();
    @(posedge dot_clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m, input logic [23:0] f);
    wr_pend = 1'b1;
    mode_in = m;
    fill_in = f;
  endtask

  task automatic do_reset();
    exp_t z;
    @(negedge dot_clk);
    rst = 1'b1;
    mode_wr = 1'b0; in_pixel_en = 1'b0; in_h_sync = 1'b0; in_v_sync = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out", out_word(), 32'd0);
    chk("rst_x", 32'(x_pos), 32'd0);
    chk("rst_y", 32'(y_pos), 32'd0);
    chk("rst_ucnt", 32'(underflow_cnt), 32'd0);
    sb.delete();
    for (int i = 0; i < PIPE; i++) begin
      z.en = 1'b1; z.val = '0; z.tag = "post_rst_zero";
      sb.push_back(z);
    end
  endtask

  initial begin
    do_reset();
    // first cycle after release: h_sync high is a rising edge
    step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 24'hFF00FF, 1, "hsync_colour");
    after_edge(); chk("y_first_hrise", 32'(y_pos), 32'd1);
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'h444444, 1, "blank_colour");
    step(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 24'hFF00FF, 1, "hv_sync_colour");
    after_edge(); chk("y_hv_rise", 32'(y_pos), 32'd0);
    step(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 24'hFF00FF, 1, "vsync_colour");
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'h444444, 1, "blank2");
    step(1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 24'h123456, 1, "pass_123456");
    after_edge(); chk("x_after_1px", 32'(x_pos), 32'd1);
    step(1, 0, 0, 1, 8'h9A, 8'hBC, 8'hDE, 24'h9ABCDE, 1, "pass_9abcde");
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 8'h55, 8'h55, 8'h55, 24'hFF0000, 1, "underflow_err");
    after_edge(); chk("ucnt_5", 32'(underflow_cnt), 32'd5);

    // shadow write mid-frame stays inactive until the next frame start
    set_mode(2'd1, 24'h000000);
    step(1, 0, 0, 1, 8'h01, 8'h02, 8'h03, 24'h010203, 1, "pass_during_wr");
    step(1, 0, 0, 1, 8'hA5, 8'h5A, 8'hC3, 24'hA55AC3, 1, "pass_after_wr");
    step(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 24'hFF00FF, 1, "frame_start_bars");
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'h444444, 1, "blank_bars");
    for (int i = 0; i < 32; i++)
      step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, (i < 16) ? 24'hFFFFFF : 24'hFFFF00, 1,
           (i < 16) ? "bar_white" : "bar_yellow");
    after_edge();
    chk("ucnt_bars_hold", 32'(underflow_cnt), 32'd5);
    chk("x_after_bars", 32'(x_pos), 32'd32);

    // strobe together with v_rise: new mode colours the same pixel
    set_mode(2'd2, 24'hAABBCC);
    step(1, 0, 1, 0, 8'h01, 8'h02, 8'h03, 24'hAABBCC, 1, "fill_same_cycle");
    step(1, 0, 0, 0, 8'h01, 8'h02, 8'h03, 24'hAABBCC, 1, "fill_next");
    set_mode(2'd3, 24'h000000);
    step(1, 0, 0, 1, 8'h01, 8'h02, 8'h03, 24'hAABBCC, 1, "fill_shadow_hold");
    step(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 24'hFF00FF, 1, "frame_start_grid");
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'h444444, 1, "blank_grid");
    step(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 24'hFF00FF, 1, "hsync_grid");
    after_edge(); chk("y_grid_line1", 32'(y_pos), 32'd1);
    step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'h444444, 1, "blank_grid2");
    for (int i = 0; i < 18; i++)
      step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, ((i % 16) == 0) ? 24'hFFFFFF : 24'h000000, 1, "grid");
    after_edge(); chk("ucnt_grid_hold", 32'(underflow_cnt), 32'd5);

    // back to pass mode and drive the counter into saturation
    set_mode(2'd0, 24'h000000);
    step(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 24'hFF00FF, 1, "frame_start_pass");
    for (int i = 0; i < 65530; i++)
      step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'hFF0000, 0, "bulk");
    after_edge(); chk("ucnt_ffff", 32'(underflow_cnt), 32'h0000FFFF);
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'hFF0000, 1, "underflow_sat_px");
    after_edge();
    chk("ucnt_sat_hold", 32'(underflow_cnt), 32'h0000FFFF);
    chk("x_sat", 32'(x_pos), 32'd2047);

    // reset with the pipeline full; shadow write pending is also discarded
    set_mode(2'd2, 24'h123456);
    step(1, 0, 0, 1, 8'h11, 8'h22, 8'h33, 24'h112233, 0, "inflight_a");
    step(1, 0, 0, 1, 8'h44, 8'h55, 8'h66, 24'h445566, 0, "inflight_b");
    do_reset();
    step(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 24'hFF00FF, 1, "post_rst_vsync");
    step(1, 0, 0, 1, 8'h77, 8'h88, 8'h99, 24'h778899, 1, "post_rst_pass");
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'hFF0000, 1, "post_rst_err");
    for (int i = 0; i < PIPE; i++)
      step(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 24'h444444, 1, "drain_blank");
    after_edge(); chk("ucnt_after_rst", 32'(underflow_cnt), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ldp_video_out.md
LDP_VIDEO_OUT -- requirements
Module: ldp_video_out

Interface
REQ-001 Parameter DW, 8, colour component width in bits (4..10).
REQ-002 Parameter PIPE, 2, input-to-output latency in dot_clk cycles (1..4).
REQ-003 Parameter BAR_SHIFT, 4, colour-bar width is 2^BAR_SHIFT pixels.
REQ-004 Parameter ERR_RGB, 24'hFF0000, substitute colour on underflow, MSB-aligned to DW.
REQ-005 Parameter SYNC_RGB, 24'hFF00FF, colour during sync, MSB-aligned to DW.
REQ-006 Parameter BLANK_RGB, 24'h444444, colour during blanking, MSB-aligned to DW.
REQ-007 dot_clk  in  1  sole clock; all logic rising-edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 mode_in  in  2  requested mode: 0 pass, 1 colour bars, 2 flat fill, 3 grid.
REQ-010 mode_wr  in  1  one-cycle strobe capturing mode_in and fill_in into shadow registers.
REQ-011 fill_in  in  3*DW  flat-fill colour {r,g,b}.
REQ-012 in_r, in_g, in_b  in  DW each  decoder pixel components.
REQ-013 in_valid  in  1  decoder pixel components are valid.
REQ-014 in_pixel_en, in_h_sync, in_v_sync  in  1 each  decoder timing.
REQ-015 out_r, out_g, out_b  out  DW each  formatted pixel.
REQ-016 out_pixel_en, out_h_sync, out_v_sync  out  1 each  timing delayed by PIPE.
REQ-017 x_pos  out  11  input-side active pixel index within line.
REQ-018 y_pos  out  10  input-side line index within frame.
REQ-019 underflow_cnt  out  16  saturating count of underflow pixels.

Function
REQ-020 Edge detect: h_rise/v_rise = input high this cycle, low the previous cycle.
REQ-021 x_pos: cleared on h_rise; otherwise +1 per cycle with in_pixel_en; saturates at 2047.
REQ-022 y_pos: cleared on v_rise; else +1 on h_rise; saturates at 1023; v_rise and h_rise in the same cycle -> y_pos=0.
REQ-023 mode_wr writes shadow registers only; the active mode and fill colour load from shadow on v_rise; mode_wr and v_rise in the same cycle -> the new value goes active in that same cycle.
REQ-024 Stage-0 colour priority, evaluated on input-side signals and current x_pos/y_pos: pixel_en -> mode colour; else sync (h or v high) -> SYNC_RGB; else BLANK_RGB.
REQ-025 Mode 0: in_valid=1 -> in_r/g/b; in_valid=0 -> ERR_RGB (underflow).
REQ-026 Mode 1: k = x_pos[BAR_SHIFT+2:BAR_SHIFT]; r = all-ones if ~k[1], g = all-ones if ~k[2], b = all-ones if ~k[0], else 0; order is white, yellow, cyan, green, magenta, red, blue, black.
REQ-027 Mode 2: active fill colour. Mode 3: all-ones when x_pos[3:0]==0 or y_pos[3:0]==0, else 0.
REQ-028 Modes 1-3 ignore in_valid and never flag underflow.
REQ-029 Stage-0 colour and pixel_en/h_sync/v_sync pass through a PIPE-deep register chain; outputs are the last stage, so timing and colour stay aligned.
REQ-030 underflow_cnt increments once per underflow pixel and holds at 16'hFFFF.

Reset
REQ-031 rst asserted asynchronously clears to 0: all outputs, the pipeline, x_pos, y_pos, underflow_cnt, edge-detect history, and the active and shadow mode and fill registers.
REQ-032 The first cycle after release behaves as reset-from-idle; a sync high in that cycle counts as a rising edge.
REQ-033 rst asserted mid-frame discards in-flight pipeline contents; nothing emerges after release.

Verification
REQ-034 Mode 0, PIPE=2, in_valid=1, pixel_en with in_r/g/b=12/34/56 at cycle t -> out 12/34/56 with out_pixel_en=1 at cycle t+2.
REQ-035 Mode 0, 5 pixel_en cycles with in_valid=0 -> five FF/00/00 output pixels; underflow_cnt=5.
REQ-036 mode_wr of mode 1 mid-frame -> output stays pass-through until the next v_sync rise; then x_pos 0-15 give white and x_pos 16-31 give yellow.
REQ-037 h_sync high with pixel_en=0 -> FF/00/FF; both low -> 44/44/44; h_rise and v_rise in the same cycle -> y_pos=0.
REQ-038 Force underflow_cnt to FFFF, then apply one more underflow pixel -> underflow_cnt stays FFFF.
REQ-039 Assert rst with the pipeline full -> all outputs 0 immediately; after release, outputs stay 0 until the first new pixel has propagated through PIPE stages.
